// File: rtl/adc_ctrl_pkg.sv
// Shared types and constants for the ADC trigger controller.
package adc_ctrl_pkg;

  // Conversion sequencing states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRIG    = 2'd1,
    RELEASE = 2'd2,
    WAIT    = 2'd3
  } state_t;

  // Shortest trigger-to-trigger spacing: two cycles high plus one forced low
  localparam int MIN_PERIOD = 3;

  // Bit of ADC_TRIGGER that carries the trigger level
  localparam int TRIG_BIT = 0;

endpackage

// File: rtl/adc_sample_fifo.sv
// Show-ahead sample FIFO. A push while full is dropped unless a pop in the
// same cycle frees a slot. rd_data is registered and reads 0 when empty.
module adc_sample_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      rd_ptr_nxt;
  logic [CNT_W-1:0]      count_nxt;
  logic [DATA_WIDTH-1:0] head_nxt;
  logic                  pop_ok;
  logic                  push_ok;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(FIFO_DEPTH));

  // Accept/drop decisions and the head value that will be visible next cycle
  always_comb begin
    pop_ok     = pop && !empty;
    push_ok    = push && (!full || pop_ok);
    rd_ptr_nxt = pop_ok ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_nxt  = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    // The incoming word becomes the head when it lands in the slot the read
    // pointer is about to point at (empty push, or push+pop at count 1).
    if (count_nxt == '0)
      head_nxt = '0;
    else if (push_ok && (wr_ptr == rd_ptr_nxt))
      head_nxt = push_data;
    else
      head_nxt = mem[rd_ptr_nxt];
  end

  // Pointers, occupancy and registered head
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr  <= rd_ptr_nxt;
      count   <= count_nxt;
      rd_data <= head_nxt;
    end
  end

  // Sample storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/adc_trigger_ctrl.sv
// ADC trigger initiator: periodic or single-shot level triggers, result
// capture into a sample FIFO, sticky timeout and overflow flags.
module adc_trigger_ctrl
  import adc_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int PERIOD_WIDTH   = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [PERIOD_WIDTH-1:0]     period,
  input  logic                        single_shot,
  output logic [DATA_WIDTH-1:0]       ADC_TRIGGER,
  input  logic [DATA_WIDTH-1:0]       MEASUREMENT,
  input  logic                        DATA_VALID_IN,
  input  logic                        rd_en,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        overflow,
  output logic                        timeout_err,
  input  logic                        err_clr
);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  // Timer reload: spacing clamped to MIN_PERIOD, minus the entry cycle itself
  function automatic logic [PERIOD_WIDTH-1:0] period_reload(input logic [PERIOD_WIDTH-1:0] p);
    logic [PERIOD_WIDTH-1:0] eff;
    eff = (p < PERIOD_WIDTH'(MIN_PERIOD)) ? PERIOD_WIDTH'(MIN_PERIOD) : p;
    return eff - PERIOD_WIDTH'(1);
  endfunction

  // Decrement that holds at zero
  function automatic logic [PERIOD_WIDTH-1:0] dec_sat(input logic [PERIOD_WIDTH-1:0] t);
    return (t == '0) ? '0 : t - PERIOD_WIDTH'(1);
  endfunction

  state_t                  state;
  state_t                  state_nxt;
  logic [PERIOD_WIDTH-1:0] timer;
  logic [TO_W-1:0]         to_cnt;
  logic                    one_shot;
  logic                    trig_r;
  logic                    start_trig;
  logic                    push;
  logic                    to_hit;
  logic                    drop;
  logic                    fifo_full;
  logic                    fifo_empty;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable || single_shot) state_nxt = TRIG;
      TRIG:    if (DATA_VALID_IN || (to_cnt == TO_LAST)) state_nxt = RELEASE;
      RELEASE: begin
        if (!enable || one_shot)  state_nxt = IDLE;
        else if (timer == '0)     state_nxt = TRIG;
        else                      state_nxt = WAIT;
      end
      WAIT: begin
        if (!enable)              state_nxt = IDLE;
        else if (timer == '0)     state_nxt = TRIG;
      end
      default:                    state_nxt = IDLE;
    endcase
  end

  // Per-cycle control strobes derived from the current and next state
  always_comb begin
    start_trig = (state_nxt == TRIG) && (state != TRIG);
    push       = (state == TRIG) && DATA_VALID_IN;
    to_hit     = (state == TRIG) && !DATA_VALID_IN && (to_cnt == TO_LAST);
    // Full implies non-empty, so rd_en always frees a slot here
    drop       = push && fifo_full && !rd_en;
  end

  // Period timer: reload on each trigger start, count down while active
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      timer <= '0;
    else if (start_trig)
      timer <= period_reload(period);
    else if (state != IDLE)
      timer <= dec_sat(timer);
  end

  // Conversion timeout counter, cleared on each trigger start
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      to_cnt <= '0;
    else if (start_trig)
      to_cnt <= '0;
    else if (state == TRIG)
      to_cnt <= to_cnt + TO_W'(1);
  end

  // Remember whether the run was started by a lone single_shot
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      one_shot <= 1'b0;
    else if ((state == IDLE) && start_trig)
      one_shot <= single_shot && !enable;
  end

  // Registered trigger level and busy flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_r <= 1'b0;
      busy   <= 1'b0;
    end else begin
      trig_r <= (state_nxt == TRIG);
      busy   <= (state_nxt != IDLE);
    end
  end

  // Sticky error flags; a new event outranks err_clr
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (drop)
        overflow <= 1'b1;
      else if (err_clr)
        overflow <= 1'b0;
      if (to_hit)
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;
    end
  end

  // Trigger bus: only the trigger bit is ever driven high
  always_comb begin
    ADC_TRIGGER           = '0;
    ADC_TRIGGER[TRIG_BIT] = trig_r;
  end

  assign rd_valid = !fifo_empty;

  adc_sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (MEASUREMENT),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: doc/adc_trigger_ctrl.md
Name: adc_trigger_ctrl

Overview:
Initiator side of the ADC trigger/measurement interface. It issues level triggers to an ADC (such as dummy_adc), either periodically or on a single-shot request. It captures each returned MEASUREMENT on DATA_VALID_IN into a small sample FIFO, and the bus/CPU side drains that FIFO. It flags conversion timeouts and FIFO overflow with sticky error bits.

Parameters:
DATA_WIDTH, 32, width of ADC_TRIGGER, MEASUREMENT and rd_data
FIFO_DEPTH, 8, sample FIFO entries; power of 2, at least 2
PERIOD_WIDTH, 16, width of the period input
TIMEOUT_CYCLES, 64, cycles in TRIG without DATA_VALID_IN before abort

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
enable  in  1  level; high = continuous periodic sampling
period  in  PERIOD_WIDTH  cycles from one trigger rise to the next; values <3 behave as 3
single_shot  in  1  one-cycle pulse; requests one conversion; honoured only in IDLE
ADC_TRIGGER  out  DATA_WIDTH  bit0 = trigger level, upper bits always 0
MEASUREMENT  in  DATA_WIDTH  ADC result, qualified by DATA_VALID_IN
DATA_VALID_IN  in  1  one-cycle result strobe from the ADC
rd_en  in  1  pop the head sample; ignored when empty
rd_data  out  DATA_WIDTH  head of FIFO (show-ahead); 0 when empty
rd_valid  out  1  FIFO non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of stored samples
busy  out  1  state != IDLE
overflow  out  1  sticky; a sample was dropped because the FIFO was full
timeout_err  out  1  sticky; a conversion timed out
err_clr  in  1  clears overflow and timeout_err

Behaviour:
- Reset values: ADC_TRIGGER=0, rd_data=0, rd_valid=0, fifo_count=0, busy=0, overflow=0, timeout_err=0. FSM goes to IDLE and the FIFO is emptied.
- Reset mid-conversion drops ADC_TRIGGER to 0 immediately, since it is asynchronous.
- All outputs are registered. ADC_TRIGGER bit0 is 1 exactly while state==TRIG.
- FSM states: IDLE, TRIG, RELEASE, WAIT.
  - IDLE -> TRIG on the edge where enable=1 or single_shot=1. ADC_TRIGGER rises after that same edge. The period timer loads period-1, with period<3 treated as 3.
  - TRIG -> RELEASE on DATA_VALID_IN=1. MEASUREMENT is pushed into the FIFO on that edge.
  - TRIG -> RELEASE when the timeout counter reaches TIMEOUT_CYCLES-1. No push occurs and timeout_err is set.
  - RELEASE always lasts exactly one cycle, guaranteeing the ADC sees a trigger low before the next rise. It then goes:
    - to TRIG if enable=1 and the period timer is 0 (late retrigger, no error);
    - to WAIT if enable=1 and the timer is nonzero;
    - to IDLE if enable=0, or if the conversion was a single_shot.
  - WAIT -> TRIG when the timer reaches 0 and enable=1. WAIT -> IDLE immediately if enable=0.
- Period timer:
  - Decrements every cycle outside IDLE and saturates at 0.
  - Reloads on every entry to TRIG.
  - Result with a one-cycle-latency ADC: trigger rises exactly every max(period,3) cycles.
- enable falling during TRIG: the conversion completes (capture or timeout), then the FSM goes to IDLE. The trigger is never cut short.
- single_shot outside IDLE is ignored. single_shot with enable=1 in IDLE starts the periodic mode.
- DATA_VALID_IN outside TRIG is ignored (stray strobe): no push, no error.
- FIFO:
  - Pointers wrap modulo FIFO_DEPTH.
  - Push while full: the sample is dropped and overflow is set. If rd_en=1 in the same cycle, the pop frees a slot and the push is accepted, so the count is unchanged.
  - Pop while empty: no effect.
  - Push and pop together while not full and not empty: count is unchanged.
- Sticky errors: err_clr clears them. If a set and err_clr occur in the same cycle, the set wins.

Decomposition:
- Package adc_ctrl_pkg holds:
  - the state enum {IDLE, TRIG, RELEASE, WAIT};
  - MIN_PERIOD=3;
  - the trigger bit index constant TRIG_BIT=0.
- Sub-module adc_sample_fifo: a synchronous show-ahead FIFO with parameters DATA_WIDTH and FIFO_DEPTH. It provides push/pop, count, full/empty, and the drop-on-full-unless-pop rule.
- FSM, timers and error flags live in the top module.

Test Plan:
1. period=10, enable=1, dummy_adc attached, no reads for 50 cycles:
   - ADC_TRIGGER rises at cycles 1, 11, 21, 31, 41;
   - each high for 2 cycles;
   - fifo_count reaches 5;
   - rd_data equals the first MEASUREMENT.
2. period=1 (clamps to 3), 30 cycles, FIFO_DEPTH=8, no reads:
   - trigger rises every 3 cycles;
   - after 8 samples, fifo_count=8;
   - the 9th capture sets overflow=1;
   - the 9th sample is absent when the FIFO is drained.
3. DATA_VALID_IN tied 0, single_shot pulse:
   - ADC_TRIGGER stays high 64 cycles then drops;
   - timeout_err=1, fifo_count=0, busy=0 two cycles later;
   - err_clr -> timeout_err=0.
4. FIFO full and capture in the same cycle as rd_en=1: fifo_count stays 8, overflow stays 0, and the new sample lands at the tail.
5. enable deasserted during TRIG: the capture still occurs and fifo_count increments by 1. Then IDLE, with no further triggers over the next 100 cycles.
6. reset asserted mid-TRIG: ADC_TRIGGER=0 and fifo_count=0 before the next clock edge. After release there are no triggers until enable or single_shot.
